ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Consumes the PS/2 scan-code byte stream and sequences its interpretation for the game.
//  An FSM parses make, break (F0) and extended (E0) prefixes and tracks held state for the
//  game keys. It emits per-key levels, a resolved move direction and one-shot press pulses
//  for fire and start. It sits between the PS/2 byte receiver and the player/game-state logic.
// PARAMETERS
//  TIMEOUT_CYCLES  2_000_000  max clk cycles between prefix and its code byte before abort (20 ms @100 MHz)
//  TO_W            21         width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  scan_byte    in   8  received scan-code byte, valid only when scan_valid=1
//  scan_valid   in   1  1-cycle strobe, one per received byte
//  held_left    out  1  left arrow (E0 6B) OR A (1C) held
//  held_right   out  1  right arrow (E0 74) OR D (23) held
//  held_fire    out  1  space (29) held
//  move         out  2  2'b01 left, 2'b10 right, 2'b00 none; never 2'b11
//  fire_pulse   out  1  1-cycle pulse on space make when space was not held
//  start_pulse  out  1  1-cycle pulse on enter (5A) make when enter was not held
//  proto_err    out  1  1-cycle pulse on prefix timeout or malformed prefix sequence
// BEHAVIOUR
//  - One clock domain. Reset asserts asynchronously; all internal state and all outputs clear to 0 in reset. FSM resets to IDLE.
//  - FSM states: IDLE, EXT, BRK, EXT_BRK. State changes happen only on scan_valid or on timeout.
//    IDLE:    E0->EXT; F0->BRK; any other byte = plain make, then stay in IDLE.
//    EXT:     F0->EXT_BRK; E0->EXT and pulse proto_err; other byte = extended make, then ->IDLE.
//    BRK:     E0->EXT and pulse proto_err; F0 stays BRK and pulses proto_err; other byte = plain break, then ->IDLE.
//    EXT_BRK: E0 or F0 -> IDLE and pulse proto_err; other byte = extended break, then ->IDLE.
//  - Codes not in the key table are parsed and ignored, with no state change beyond FSM return.
//    Plain E0 6B / E0 74 are distinct keys from plain 6B/74; plain 6B/74 are ignored.
//  - Internal held bits: arr_l, arr_r, key_a, key_d, spc, ent.
//    Make sets the bit; break clears it. Break for a key not held is a no-op.
//  - held_left=arr_l|key_a, held_right=arr_r|key_d, held_fire=spc.
//    Registered outputs: updated on the cycle after the byte that completes the code.
//  - Typematic repeat (repeated make while held) changes no state and produces no pulse.
//  - fire_pulse/start_pulse assert one cycle on the same edge that sets spc/ent from 0.
//  - move uses a last-pressed register `last` (L/R).
//    A make that takes held_left 0->1 sets last=L; a make that takes held_right 0->1 sets last=R.
//    move = both held ? (last==L ? 01 : 10) : held_left ? 01 : held_right ? 10 : 00.
//    move is registered with the same 1-cycle latency as held_*.
//  - Timeout counter clears on every scan_valid and counts while the FSM is not in IDLE.
//    On reaching TIMEOUT_CYCLES: FSM -> IDLE, one proto_err pulse, held bits unchanged.
//    The counter saturates and holds in IDLE.
//  - scan_valid in the same cycle as a timeout: the byte wins. It is processed in the current
//    state, no timeout error is raised, and the counter clears.
//  - scan_valid on consecutive cycles is legal; each byte is processed in order, with no buffering.
// TESTING
//  1. Reset released, no bytes -> all outputs 0, move=00; assert rst_n mid-sequence (after E0) -> all 0, next 6B ignored as plain.
//  2. Bytes 29, 29, 29 -> fire_pulse exactly once, held_fire=1; then F0 29 -> held_fire=0, no pulse.
//  3. E0 6B -> held_left=1, move=01; then 23 -> move=10 (last=R); then F0 23 -> move=01; then E0 F0 6B -> move=00.
//  4. 1C, then E0 6B, then F0 1C -> held_left stays 1 throughout; then E0 F0 6B -> held_left=0.
//  5. E0 then idle TIMEOUT_CYCLES -> one proto_err, FSM IDLE; next 74 (plain) -> held_right stays 0.
//  6. F0 E0 F0 74 with 74 pre-held via E0 74 -> proto_err on E0 pulse, then held_right=0; 5A then 5A -> start_pulse once.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code parser: decodes make/break/extended prefixes into held game keys,
// a resolved move direction, one-shot fire/start pulses and a protocol-error pulse.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned TO_W           = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_byte,
  input  logic       scan_valid,
  output logic       held_left,
  output logic       held_right,
  output logic       held_fire,
  output logic [1:0] move,
  output logic       fire_pulse,
  output logic       start_pulse,
  output logic       proto_err
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  typedef enum logic {LAST_L, LAST_R} last_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam int unsigned K_ARL = 0;
  localparam int unsigned K_ARR = 1;
  localparam int unsigned K_A   = 2;
  localparam int unsigned K_D   = 3;
  localparam int unsigned K_SPC = 4;
  localparam int unsigned K_ENT = 5;

  state_t          state, state_n;
  last_t           last, last_n;
  logic [TO_W-1:0] cnt;
  logic [5:0]      keys, keys_n, hit;
  logic            mk, brk, ext, perr_n, timeout;
  logic            hl_n, hr_n, hl_cur, hr_cur;

  always_comb begin
    state_n = state;
    mk      = 1'b0;
    brk     = 1'b0;
    ext     = 1'b0;
    perr_n  = 1'b0;
    timeout = (state != IDLE) && (cnt == TO_LAST) && !scan_valid;
    if (scan_valid) begin
      unique case (state)
        IDLE: begin
          if (scan_byte == CODE_EXT)      state_n = EXT;
          else if (scan_byte == CODE_BRK) state_n = BRK;
          else                            mk = 1'b1;
        end
        EXT: begin
          if (scan_byte == CODE_BRK)      state_n = EXT_BRK;
          else if (scan_byte == CODE_EXT) perr_n = 1'b1;
          else begin
            mk      = 1'b1;
            ext     = 1'b1;
            state_n = IDLE;
          end
        end
        BRK: begin
          if (scan_byte == CODE_EXT) begin
            state_n = EXT;
            perr_n  = 1'b1;
          end else if (scan_byte == CODE_BRK) begin
            perr_n  = 1'b1;
          end else begin
            brk     = 1'b1;
            state_n = IDLE;
          end
        end
        EXT_BRK: begin
          state_n = IDLE;
          if (scan_byte == CODE_EXT || scan_byte == CODE_BRK) perr_n = 1'b1;
          else begin
            brk = 1'b1;
            ext = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      state_n = IDLE;
      perr_n  = 1'b1;
    end
  end

  // Arrow keys only exist with the E0 prefix; letter/space/enter only without it.
  always_comb begin
    hit        = '0;
    hit[K_ARL] = ext  && (scan_byte == 8'h6B);
    hit[K_ARR] = ext  && (scan_byte == 8'h74);
    hit[K_A]   = !ext && (scan_byte == 8'h1C);
    hit[K_D]   = !ext && (scan_byte == 8'h23);
    hit[K_SPC] = !ext && (scan_byte == 8'h29);
    hit[K_ENT] = !ext && (scan_byte == 8'h5A);
  end

  always_comb begin
    keys_n = keys;
    if (mk)       keys_n = keys | hit;
    else if (brk) keys_n = keys & ~hit;
    hl_cur = keys[K_ARL] | keys[K_A];
    hr_cur = keys[K_ARR] | keys[K_D];
    hl_n   = keys_n[K_ARL] | keys_n[K_A];
    hr_n   = keys_n[K_ARR] | keys_n[K_D];
    last_n = last;
    if (mk && hl_n && !hl_cur)      last_n = LAST_L;
    else if (mk && hr_n && !hr_cur) last_n = LAST_R;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= LAST_L;
      cnt         <= '0;
      keys        <= '0;
      held_left   <= 1'b0;
      held_right  <= 1'b0;
      held_fire   <= 1'b0;
      move        <= 2'b00;
      fire_pulse  <= 1'b0;
      start_pulse <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state <= state_n;
      last  <= last_n;
      keys  <= keys_n;
      // Reaching TO_MAX also drops the FSM to IDLE, where the count then holds.
      if (scan_valid)                             cnt <= '0;
      else if (state != IDLE && cnt != TO_MAX)    cnt <= cnt + 1'b1;
      held_left   <= hl_n;
      held_right  <= hr_n;
      held_fire   <= keys_n[K_SPC];
      if (hl_n && hr_n) move <= (last_n == LAST_L) ? 2'b01 : 2'b10;
      else if (hl_n)    move <= 2'b01;
      else if (hr_n)    move <= 2'b10;
      else              move <= 2'b00;
      fire_pulse  <= mk && hit[K_SPC] && !keys[K_SPC];
      start_pulse <= mk && hit[K_ENT] && !keys[K_ENT];
      proto_err   <= perr_n;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: expected output vectors are queued as each byte
// is driven and popped for comparison once the registered outputs have updated.
module tb_ps2_key_tracker;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scan_byte = 8'h00;
  logic       scan_valid = 1'b0;
  logic       held_left, held_right, held_fire, fire_pulse, start_pulse, proto_err;
  logic [1:0] move;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;
  exp_t       sb[$];
  logic [8:0] last_exp = '0;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .scan_byte(scan_byte), .scan_valid(scan_valid),
    .held_left(held_left), .held_right(held_right), .held_fire(held_fire),
    .move(move), .fire_pulse(fire_pulse), .start_pulse(start_pulse), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Vector layout: {held_left, held_right, held_fire, move[1:0], fire, start, err}
  function automatic logic [8:0] ex(input logic hl, input logic hr, input logic hf,
                                    input logic [1:0] mv, input logic f, input logic s,
                                    input logic e);
    return {hl, hr, hf, mv, f, s, e};
  endfunction

  function automatic logic [8:0] obs();
    return {held_left, held_right, held_fire, move, fire_pulse, start_pulse, proto_err};
  endfunction

  task automatic push(input string tag, input logic [8:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
    last_exp = v;
  endtask

  task automatic check_front();
    exp_t e;
    logic [8:0] o;
    e = sb.pop_front();
    o = obs();
    checks++;
    assert (o === e.v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (hl hr hf mv mv f s e)", e.tag, o, e.v);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    scan_byte  = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1 scan_valid = 1'b0;
  endtask

  task automatic drive2(input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk);
    scan_byte  = b1;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_byte  = b2;
    @(posedge clk);
    #1 scan_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input string tag, input logic [8:0] v);
    push(tag, v);
    drive(b);
    check_front();
  endtask

  // One further cycle with no byte: levels hold and every pulse has dropped.
  task automatic tick_check(input string tag);
    push(tag, last_exp & 9'b111111000);
    @(posedge clk);
    #1 check_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [8:0] z;
    z = '0;

    // Reset behaviour, including reset asserted after a dangling E0.
    #1 push("in_reset", z); check_front();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 push("after_reset", z); check_front();
    send(8'hE0, "rst_e0", z);
    #2 rst_n = 1'b0;
    #1 push("async_reset", z); check_front();
    @(negedge clk); rst_n = 1'b1;
    send(8'h6B, "plain_6b_ignored", z);
    tick_check("plain_6b_idle");

    // Space typematic and release.
    send(8'h29, "spc_make", ex(0,0,1,2'b00,1,0,0));
    tick_check("spc_pulse_drop");
    send(8'h29, "spc_rep1", ex(0,0,1,2'b00,0,0,0));
    send(8'h29, "spc_rep2", ex(0,0,1,2'b00,0,0,0));
    send(8'hF0, "spc_f0", ex(0,0,1,2'b00,0,0,0));
    send(8'h29, "spc_break", z);

    // Arrow left, then D overrides, released in turn.
    send(8'hE0, "al_e0", z);
    send(8'h6B, "al_make", ex(1,0,0,2'b01,0,0,0));
    send(8'h23, "d_make", ex(1,1,0,2'b10,0,0,0));
    send(8'hF0, "d_f0", ex(1,1,0,2'b10,0,0,0));
    send(8'h23, "d_break", ex(1,0,0,2'b01,0,0,0));
    send(8'hE0, "al_e0b", ex(1,0,0,2'b01,0,0,0));
    send(8'hF0, "al_f0", ex(1,0,0,2'b01,0,0,0));
    send(8'h6B, "al_break", z);

    // A and arrow-left overlap on held_left.
    send(8'h1C, "a_make", ex(1,0,0,2'b01,0,0,0));
    send(8'hE0, "ov_e0", ex(1,0,0,2'b01,0,0,0));
    send(8'h6B, "ov_al", ex(1,0,0,2'b01,0,0,0));
    send(8'hF0, "ov_f0", ex(1,0,0,2'b01,0,0,0));
    send(8'h1C, "a_break_still", ex(1,0,0,2'b01,0,0,0));
    send(8'hE0, "ov_e0b", ex(1,0,0,2'b01,0,0,0));
    send(8'hF0, "ov_f0b", ex(1,0,0,2'b01,0,0,0));
    send(8'h6B, "ov_al_break", z);

    // Last-pressed wins; typematic of A while D newer does not steal direction.
    send(8'h1C, "lp_a", ex(1,0,0,2'b01,0,0,0));
    send(8'h23, "lp_d", ex(1,1,0,2'b10,0,0,0));
    send(8'h1C, "lp_a_rep", ex(1,1,0,2'b10,0,0,0));
    send(8'hF0, "lp_f0", ex(1,1,0,2'b10,0,0,0));
    send(8'h23, "lp_d_brk", ex(1,0,0,2'b01,0,0,0));
    send(8'h23, "lp_d_again", ex(1,1,0,2'b10,0,0,0));
    send(8'hF0, "lp_f0b", ex(1,1,0,2'b10,0,0,0));
    send(8'h1C, "lp_a_brk", ex(0,1,0,2'b10,0,0,0));
    send(8'h1C, "lp_a_new", ex(1,1,0,2'b01,0,0,0));
    send(8'hF0, "lp_f0c", ex(1,1,0,2'b01,0,0,0));
    send(8'h1C, "lp_a_brk2", ex(0,1,0,2'b10,0,0,0));
    send(8'hF0, "lp_f0d", ex(0,1,0,2'b10,0,0,0));
    send(8'h23, "lp_d_brk2", z);
    send(8'hF0, "brk_unheld_f0", z);
    send(8'h29, "brk_unheld", z);

    // Prefix timeout with no byte.
    send(8'hE0, "to_e0", z);
    n = 0;
    for (int i = 1; i <= 4 * T; i++) begin
      @(posedge clk);
      #1;
      if (proto_err === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    assert (n == T) else begin
      errors++;
      $error("FAIL timeout_latency: observed %0d cycles expected %0d", n, T);
    end
    push("to_err", ex(0,0,0,2'b00,0,0,1)); check_front();
    tick_check("to_err_drop");
    send(8'h74, "to_plain_74", z);

    // Byte arriving on the timeout cycle wins.
    send(8'hE0, "race_e0", z);
    repeat (T - 1) @(posedge clk);
    push("race_74", ex(0,1,0,2'b10,0,0,0));
    drive(8'h74);
    check_front();
    for (int i = 0; i < 3; i++) tick_check("race_no_err");

    // Malformed prefixes; E0 74 delivered back-to-back.
    push("b2b_e0_74", ex(0,1,0,2'b10,0,0,0));
    drive2(8'hE0, 8'h74);
    check_front();
    send(8'hF0, "m_f0", ex(0,1,0,2'b10,0,0,0));
    send(8'hE0, "m_brk_e0", ex(0,1,0,2'b10,0,0,1));
    send(8'hF0, "m_f0_ext", ex(0,1,0,2'b10,0,0,0));
    send(8'h74, "m_ar_break", z);
    send(8'hF0, "m_f0f0a", z);
    send(8'hF0, "m_f0f0b", ex(0,0,0,2'b00,0,0,1));
    send(8'h29, "m_f0f0_brk", z);
    send(8'hE0, "m_e0e0a", z);
    send(8'hE0, "m_e0e0b", ex(0,0,0,2'b00,0,0,1));
    send(8'h6B, "m_e0e0_al", ex(1,0,0,2'b01,0,0,0));
    send(8'hE0, "m_eb_e0", ex(1,0,0,2'b01,0,0,0));
    send(8'hF0, "m_eb_f0", ex(1,0,0,2'b01,0,0,0));
    send(8'hF0, "m_eb_f0f0", ex(1,0,0,2'b01,0,0,1));
    send(8'h6B, "m_eb_plain6b", ex(1,0,0,2'b01,0,0,0));
    send(8'hE0, "m_cl_e0", ex(1,0,0,2'b01,0,0,0));
    send(8'hF0, "m_cl_f0", ex(1,0,0,2'b01,0,0,0));
    send(8'h6B, "m_cl_6b", z);

    // Enter start pulse once per press.
    send(8'h5A, "ent_make", ex(0,0,0,2'b00,0,1,0));
    send(8'h5A, "ent_rep", z);
    send(8'hF0, "ent_f0", z);
    send(8'h5A, "ent_brk", z);
    send(8'h5A, "ent_make2", ex(0,0,0,2'b00,0,1,0));
    tick_check("ent_drop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
